// File: rtl/ble_crc_pkg.sv
// Shared types, constants and the CRC24 LFSR step for the BLE receive CRC checker.
// Polynomial x^24+x^10+x^9+x^6+x^4+x^3+x+1, Galois form, MSB is the feedback tap.
package ble_crc_pkg;

  localparam int CRC24_W  = 24;
  localparam logic [CRC24_W-1:0] CRC24_POLY = 24'h00065B;
  localparam int HDR_BITS = 16;
  localparam int CNT_W    = 11;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAYLOAD,
    CRC,
    DONE
  } rx_state_t;

  // One serial step: shift left, feed back into bit 0 and the tap positions.
  function automatic logic [CRC24_W-1:0] crc24_step(input logic [CRC24_W-1:0] lfsr,
                                                    input logic din);
    logic fb;
    fb = din ^ lfsr[CRC24_W-1];
    return {lfsr[CRC24_W-2:0], 1'b0} ^ ({CRC24_W{fb}} & CRC24_POLY);
  endfunction

endpackage

// File: rtl/ble_rx_crc24_check_if.sv
// Serial bit-stream bundle around the CRC checker: de-whitened bits in,
// header/payload bits out with a last marker.
interface ble_rx_crc24_check_if;
  logic in_tdata;
  logic in_tvalid;
  logic out_tdata;
  logic out_tvalid;
  logic out_tlast;

  modport master (output in_tdata, output in_tvalid,
                  input  out_tdata, input out_tvalid, input out_tlast);
  modport slave  (input  in_tdata, input in_tvalid,
                  output out_tdata, output out_tvalid, output out_tlast);
endinterface

// File: rtl/ble_rx_crc24_check.sv
// BLE receive CRC24 checker: parses the PDU header, forwards header/payload bits
// one cycle late and checks the trailing CRC. Optional error counter: BLE_RX_CRC_ERR_CNT_EN.
module ble_rx_crc24_check
  import ble_crc_pkg::*;
#(
  parameter int unsigned MAX_LEN = 255
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     start,
  input  logic [CRC24_W-1:0]       init_preset,
  ble_rx_crc24_check_if.slave      bus,
  output logic                     busy,
  output logic                     done,
  output logic                     crc_ok,
  output logic                     len_err,
  output logic [7:0]               pdu_len,
  output logic [CRC24_W-1:0]       rx_crc
`ifdef BLE_RX_CRC_ERR_CNT_EN
  ,
  output logic [15:0]              err_count
`endif
);

  rx_state_t          state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CRC24_W-1:0] lfsr_q, lfsr_d;
  logic [CRC24_W-1:0] rx_crc_q, rx_crc_d;
  logic [7:0]         pdu_len_q, pdu_len_d;
  logic               crc_ok_q, crc_ok_d;
  logic               len_err_q, len_err_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               out_tdata_q, out_tdata_d;
  logic               out_tvalid_q, out_tvalid_d;
  logic               out_tlast_q, out_tlast_d;

  logic [7:0]         len_next;
  logic [CRC24_W-1:0] rx_crc_next;
  logic               hdr_last, payload_last, crc_last;

  assign len_next     = {bus.in_tdata, pdu_len_q[7:1]};
  assign rx_crc_next  = {rx_crc_q[CRC24_W-2:0], bus.in_tdata};
  assign hdr_last     = (bit_cnt_q == CNT_W'(HDR_BITS - 1));
  assign payload_last = (bit_cnt_q == ({pdu_len_q, 3'b000} - CNT_W'(1)));
  assign crc_last     = (bit_cnt_q == CNT_W'(CRC24_W - 1));

  // NOTE: every signal assigned here gets a default first, otherwise paths that
  // skip an assignment would infer latches.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    lfsr_d       = lfsr_q;
    rx_crc_d     = rx_crc_q;
    pdu_len_d    = pdu_len_q;
    crc_ok_d     = crc_ok_q;
    len_err_d    = len_err_q;
    out_tdata_d  = 1'b0;
    out_tvalid_d = 1'b0;
    out_tlast_d  = 1'b0;

    if (start) begin
      // A bit arriving together with start belongs to no frame and is dropped.
      state_d   = HDR;
      bit_cnt_d = '0;
      lfsr_d    = init_preset;
      rx_crc_d  = '0;
      pdu_len_d = '0;
      crc_ok_d  = 1'b0;
      len_err_d = 1'b0;
    end else begin
      case (state_q)
        HDR: if (bus.in_tvalid) begin
          lfsr_d       = crc24_step(lfsr_q, bus.in_tdata);
          out_tdata_d  = bus.in_tdata;
          out_tvalid_d = 1'b1;
          bit_cnt_d    = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q >= CNT_W'(HDR_BITS / 2)) pdu_len_d = len_next;
          if (hdr_last) begin
            bit_cnt_d = '0;
            if (len_next == 8'd0) begin
              state_d     = CRC;
              out_tlast_d = 1'b1;
            end else if (32'(len_next) > MAX_LEN) begin
              state_d   = DONE;
              len_err_d = 1'b1;
              crc_ok_d  = 1'b0;
            end else begin
              state_d = PAYLOAD;
            end
          end
        end
        PAYLOAD: if (bus.in_tvalid) begin
          lfsr_d       = crc24_step(lfsr_q, bus.in_tdata);
          out_tdata_d  = bus.in_tdata;
          out_tvalid_d = 1'b1;
          bit_cnt_d    = bit_cnt_q + CNT_W'(1);
          if (payload_last) begin
            bit_cnt_d   = '0;
            state_d     = CRC;
            out_tlast_d = 1'b1;
          end
        end
        CRC: if (bus.in_tvalid) begin
          rx_crc_d  = rx_crc_next;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (crc_last) begin
            crc_ok_d = (rx_crc_next == lfsr_q);
            state_d  = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // DONE always falls back to IDLE, so entering it is exactly the done pulse.
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      lfsr_q       <= '0;
      rx_crc_q     <= '0;
      pdu_len_q    <= '0;
      crc_ok_q     <= 1'b0;
      len_err_q    <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      out_tdata_q  <= 1'b0;
      out_tvalid_q <= 1'b0;
      out_tlast_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      lfsr_q       <= lfsr_d;
      rx_crc_q     <= rx_crc_d;
      pdu_len_q    <= pdu_len_d;
      crc_ok_q     <= crc_ok_d;
      len_err_q    <= len_err_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      out_tdata_q  <= out_tdata_d;
      out_tvalid_q <= out_tvalid_d;
      out_tlast_q  <= out_tlast_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign crc_ok         = crc_ok_q;
  assign len_err        = len_err_q;
  assign pdu_len        = pdu_len_q;
  assign rx_crc         = rx_crc_q;
  assign bus.out_tdata  = out_tdata_q;
  assign bus.out_tvalid = out_tvalid_q;
  assign bus.out_tlast  = out_tlast_q;

`ifdef BLE_RX_CRC_ERR_CNT_EN
  logic [15:0] err_count_q, err_count_d;

  // Length aborts count as failures too; the counter sticks at all-ones.
  always_comb begin
    err_count_d = err_count_q;
    if (done_d && !crc_ok_d && (err_count_q != 16'hFFFF))
      err_count_d = err_count_q + 16'd1;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) err_count_q <= '0;
    else          err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`endif

endmodule
